// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the RX framing state encoding.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;

  // Holding back this many bytes lets the 4 FCS bytes drop off the end of the stream.
  localparam int          DL_DEPTH        = 5;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    END,
    DROP
  } rx_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide reflected CRC-32 next-state, LSB of the byte first. Pure combinational.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  logic [31:0] c [0:8];

  assign c[0] = crc_in;

  // One shift/conditional-xor step per data bit, bit 0 first.
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign c[i+1] = {1'b0, c[i][31:1]} ^ ({32{c[i][0] ^ d[i]}} & CRC32_POLY_REFL);
  end

  assign crc_out = c[8];

endmodule

// File: rtl/eth_rx_fcs_check.sv
// GMII receive framer: strips preamble/SFD, checks FCS, hides the FCS bytes from
// the output stream and reports per-frame status.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [7:0]       rxd,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             stat_valid,
  output logic             stat_good,
  output logic             stat_crc_err,
  output logic             stat_runt,
  output logic             stat_long,
  output logic             stat_phy_err,
  output logic [CNT_W-1:0] stat_len
);

  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

  rx_state_e                     state_q, state_d;
  logic                          start, push, fin;

  logic [31:0]                   crc_q, crc_nxt;
  logic [CNT_W-1:0]              cnt_q;
  logic [DL_DEPTH-1:0][7:0]      dl_q;       // [0] newest, [DL_DEPTH-1] oldest
  logic [2:0]                    dl_cnt_q;
  logic                          dl_full;
  logic                          phy_err_q;

  logic [7:0]                    m_data_q;
  logic                          m_valid_q, m_last_q, stat_valid_q;
  logic                          good_q, crc_err_q, runt_q, long_q, phy_q;
  logic [CNT_W-1:0]              len_q;

  logic                          crc_bad, is_runt, is_long;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .d       (rxd),
    .crc_out (crc_nxt)
  );

  assign dl_full = (dl_cnt_q == 3'(DL_DEPTH));
  assign crc_bad = (crc_q != CRC32_RESIDUE);
  assign is_runt = (cnt_q < MIN_L);
  assign is_long = (cnt_q > MAX_L);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state plus datapath strobes: start = SFD seen, push = data byte, fin = frame ended.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    push    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_dv) begin
          if (rxd == ETH_PREAMBLE) begin
            state_d = PREAMBLE;
          end else if (rxd == ETH_SFD) begin
            state_d = DATA;
            start   = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rxd == ETH_SFD) begin
          state_d = DATA;
          start   = 1'b1;
        end else if (rxd != ETH_PREAMBLE) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (rx_dv) begin
          push = 1'b1;
        end else begin
          fin     = 1'b1;
          state_d = END;
        end
      end
      // END spends its single cycle presenting status; a byte arriving now has no SFD.
      END:     state_d = rx_dv ? DROP : IDLE;
      DROP:    if (!rx_dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: CRC, length counter, delay line and registered outputs. Registering
  // the final byte and status on the DATA->END edge makes them visible during END.
  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q        <= CRC32_INIT;
      cnt_q        <= '0;
      dl_q         <= '0;
      dl_cnt_q     <= '0;
      phy_err_q    <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      stat_valid_q <= 1'b0;
      good_q       <= 1'b0;
      crc_err_q    <= 1'b0;
      runt_q       <= 1'b0;
      long_q       <= 1'b0;
      phy_q        <= 1'b0;
      len_q        <= '0;
    end else begin
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      stat_valid_q <= 1'b0;

      if (start) begin
        crc_q     <= CRC32_INIT;
        cnt_q     <= '0;
        dl_cnt_q  <= '0;
        phy_err_q <= 1'b0;
      end

      if (push) begin
        crc_q <= crc_nxt;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
        dl_q <= {dl_q[DL_DEPTH-2:0], rxd};
        if (!dl_full) dl_cnt_q <= dl_cnt_q + 3'd1;
        if (rx_er) phy_err_q <= 1'b1;
        // Line already full: the byte falling out is known not to be FCS.
        if (dl_full) begin
          m_data_q  <= dl_q[DL_DEPTH-1];
          m_valid_q <= 1'b1;
        end
      end

      if (fin) begin
        // The oldest held byte is the last data byte; the other four are FCS.
        if (dl_full) begin
          m_data_q  <= dl_q[DL_DEPTH-1];
          m_valid_q <= 1'b1;
          m_last_q  <= 1'b1;
        end
        stat_valid_q <= 1'b1;
        crc_err_q    <= crc_bad;
        runt_q       <= is_runt;
        long_q       <= is_long;
        phy_q        <= phy_err_q;
        good_q       <= !crc_bad && !is_runt && !is_long && !phy_err_q;
        len_q        <= cnt_q;
      end
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign stat_valid   = stat_valid_q;
  assign stat_good    = good_q;
  assign stat_crc_err = crc_err_q;
  assign stat_runt    = runt_q;
  assign stat_long    = long_q;
  assign stat_phy_err = phy_q;
  assign stat_len     = len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench: two instances (default MIN_LEN and MIN_LEN=5) share one GMII stimulus.
module tb_eth_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_dv = 1'b0, rx_er = 1'b0;
  logic [7:0]  rxd = 8'h00;

  logic [7:0]  a_data, b_data;
  logic        a_valid, a_last, a_sval, a_good, a_crc, a_runt, a_long, a_phy;
  logic        b_valid, b_last, b_sval, b_good, b_crc, b_runt, b_long, b_phy;
  logic [11:0] a_len, b_len;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [7:0] d; logic last; } exp_byte_t;
  exp_byte_t   qa[$], qb[$], ea, eb;
  logic [16:0] sa[$], sb[$], esa, esb;   // {good,crc,runt,long,phy,len}
  logic [7:0]  fb[$];

  always #4 clk = ~clk;

  eth_rx_fcs_check u_dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .m_data(a_data), .m_valid(a_valid), .m_last(a_last), .stat_valid(a_sval),
    .stat_good(a_good), .stat_crc_err(a_crc), .stat_runt(a_runt), .stat_long(a_long),
    .stat_phy_err(a_phy), .stat_len(a_len)
  );

  eth_rx_fcs_check #(.MIN_LEN(5)) u_small (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .m_data(b_data), .m_valid(b_valid), .m_last(b_last), .stat_valid(b_sval),
    .stat_good(b_good), .stat_crc_err(b_crc), .stat_runt(b_runt), .stat_long(b_long),
    .stat_phy_err(b_phy), .stat_len(b_len)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor for the default-parameter instance.
  always @(negedge clk) begin
    if (a_valid) begin
      if (qa.size() == 0) chk("a_unexpected_byte", {24'h0, a_data}, 32'hFFFFFFFF);
      else begin
        ea = qa.pop_front();
        chk("a_data", {24'h0, a_data}, {24'h0, ea.d});
        chk("a_last", {31'h0, a_last}, {31'h0, ea.last});
      end
    end
    if (a_sval) begin
      if (sa.size() == 0) chk("a_unexpected_status", {31'h0, a_sval}, 32'h0);
      else begin
        esa = sa.pop_front();
        chk("a_status", {15'h0, a_good, a_crc, a_runt, a_long, a_phy, a_len}, {15'h0, esa});
      end
    end
    if (a_last) chk("a_stat_with_last", {31'h0, a_sval}, 32'h1);
  end

  // Monitor for the MIN_LEN=5 instance.
  always @(negedge clk) begin
    if (b_valid) begin
      if (qb.size() == 0) chk("b_unexpected_byte", {24'h0, b_data}, 32'hFFFFFFFF);
      else begin
        eb = qb.pop_front();
        chk("b_data", {24'h0, b_data}, {24'h0, eb.d});
        chk("b_last", {31'h0, b_last}, {31'h0, eb.last});
      end
    end
    if (b_sval) begin
      if (sb.size() == 0) chk("b_unexpected_status", {31'h0, b_sval}, 32'h0);
      else begin
        esb = sb.pop_front();
        chk("b_status", {15'h0, b_good, b_crc, b_runt, b_long, b_phy, b_len}, {15'h0, esb});
      end
    end
    if (b_last) chk("b_stat_with_last", {31'h0, b_sval}, 32'h1);
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // n-4 pattern bytes (never 55/D5) followed by the FCS, least significant byte first.
  task automatic build(input int n, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    fb.delete();
    c = 32'hFFFFFFFF;
    for (int j = 0; j < n - 4; j++) begin
      b = 8'(j * 13 + seed * 29 + 7);
      if (b == 8'h55 || b == 8'hD5) b = b ^ 8'h01;
      fb.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    fb.push_back(c[7:0]);  fb.push_back(c[15:8]);
    fb.push_back(c[23:16]); fb.push_back(c[31:24]);
  endtask

  task automatic expect_frame(input int n, input bit crc_bad, input bit phy);
    logic ra, rb, lg;
    logic [11:0] len;
    for (int i = 0; i <= n - 5; i++) begin
      qa.push_back('{d: fb[i], last: (i == n - 5)});
      qb.push_back('{d: fb[i], last: (i == n - 5)});
    end
    ra  = (n < 64);
    rb  = (n < 5);
    lg  = (n > 1518);
    len = (n > 4095) ? 12'hFFF : 12'(n);
    sa.push_back({!(crc_bad || ra || lg || phy), crc_bad, ra, lg, phy, len});
    sb.push_back({!(crc_bad || rb || lg || phy), crc_bad, rb, lg, phy, len});
  endtask

  task automatic send_byte(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    rx_dv = dv; rx_er = er; rxd = d;
  endtask

  task automatic send_pre();
    for (int i = 0; i < 7; i++) send_byte(1'b1, 1'b0, 8'h55);
    send_byte(1'b1, 1'b0, 8'hD5);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_byte(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int er_idx);
    send_pre();
    for (int i = 0; i < fb.size(); i++) send_byte(1'b1, (i == er_idx), fb[i]);
    idle(12);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_outputs"}, {11'h0, a_data, a_valid, a_last, a_sval, a_good, a_crc, a_runt, a_long, a_phy, a_len}, 32'h0);
    chk({tag, "_b_outputs"}, {11'h0, b_data, b_valid, b_last, b_sval, b_good, b_crc, b_runt, b_long, b_phy, b_len}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    idle(3);

    // Reference vector "123456789" with its FCS.
    fb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    expect_frame(13, 1'b0, 1'b0);
    send_frame(-1);

    // Same frame, bit 0 of '5' flipped.
    fb[4] = 8'h34;
    expect_frame(13, 1'b1, 1'b0);
    send_frame(-1);

    // Valid 60-byte frame: runt only with default MIN_LEN.
    build(60, 1);
    expect_frame(60, 1'b0, 1'b0);
    send_frame(-1);

    // rx_er mid-frame, then a clean frame.
    build(64, 2);
    expect_frame(64, 1'b0, 1'b1);
    send_frame(20);
    build(64, 3);
    expect_frame(64, 1'b0, 1'b0);
    send_frame(-1);

    // Broken preamble: dropped silently, next frame normal.
    for (int i = 0; i < 7; i++) send_byte(1'b1, 1'b0, 8'h55);
    send_byte(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 10; i++) send_byte(1'b1, 1'b0, 8'(i + 1));
    idle(6);
    build(64, 4);
    expect_frame(64, 1'b0, 1'b0);
    send_frame(-1);

    // Tiny frame: no data out, runt + CRC error.
    fb = '{8'h01, 8'h02, 8'h03};
    expect_frame(3, 1'b1, 1'b0);
    send_frame(-1);

    // Length boundaries around MAX_LEN.
    build(1518, 5);
    expect_frame(1518, 1'b0, 1'b0);
    send_frame(-1);
    build(1519, 6);
    expect_frame(1519, 1'b0, 1'b0);
    send_frame(-1);

    // Good frame so the status registers hold non-zero before the reset test.
    build(64, 7);
    expect_frame(64, 1'b0, 1'b0);
    send_frame(-1);

    // Reset at byte 30 of a 100-byte frame: bytes 0..24 already out, nothing else.
    build(100, 8);
    for (int i = 0; i < 25; i++) begin
      qa.push_back('{d: fb[i], last: 1'b0});
      qb.push_back('{d: fb[i], last: 1'b0});
    end
    send_pre();
    for (int i = 0; i < 30; i++) send_byte(1'b1, 1'b0, fb[i]);
    @(negedge clk);
    rst = 1'b0; rx_dv = 1'b1; rx_er = 1'b0; rxd = fb[30];
    @(negedge clk);
    chk_zero("midreset");
    rst = 1'b1; rxd = fb[31];
    for (int i = 32; i < 100; i++) send_byte(1'b1, 1'b0, fb[i]);
    idle(12);

    build(64, 9);
    expect_frame(64, 1'b0, 1'b0);
    send_frame(-1);

    idle(20);
    chk("a_pending_bytes", qa.size(), 0);
    chk("b_pending_bytes", qb.size(), 0);
    chk("a_pending_status", sa.size(), 0);
    chk("b_pending_status", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
